// File: rtl/lpddr_burst_ring_sequencer_if.sv
// Command/address bundle between the burst requesters and the ring sequencer.
// The master side raises burst requests; the slave side (the sequencer) returns
// command strobes, burst byte addresses and commit acknowledges.
interface lpddr_burst_ring_sequencer_if #(
   parameter int ADDR_W = 30
);
   logic              wr_req;
   logic              rd_req;
   logic              cmd_en_wr;
   logic [ADDR_W-1:0] wr_byte_addr;
   logic              cmd_en_rd;
   logic [ADDR_W-1:0] rd_byte_addr;
   logic              wr_ack;
   logic              rd_ack;

   modport master (
      output wr_req, rd_req,
      input  cmd_en_wr, wr_byte_addr, cmd_en_rd, rd_byte_addr, wr_ack, rd_ack
   );

   modport slave (
      input  wr_req, rd_req,
      output cmd_en_wr, wr_byte_addr, cmd_en_rd, rd_byte_addr, wr_ack, rd_ack
   );
endinterface

// File: rtl/lpddr_burst_ring_sequencer.sv
// Burst ring sequencer for the LPDDR write/read port pair. A DDR region is
// treated as a ring of fixed-size bursts; write and read burst pointers,
// occupancy and full/empty flags are kept here, and one burst command at a
// time is issued with a registered, stable byte address.
module lpddr_burst_ring_sequencer #(
   parameter int                ADDR_W      = 30,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 30'h0000_0080,
   parameter int                BURST_BYTES = 128,
   parameter int                NUM_BURSTS  = 4096,
   parameter int                LVL_W       = 17
) (
   input  logic                        clkA_addr,
   input  logic                        addr_rstA_wr,
   input  logic                        calib_done,
   lpddr_burst_ring_sequencer_if.slave bus,
   output logic [LVL_W-1:0]            level,
   output logic                        ring_full,
   output logic                        ring_empty,
   output logic                        overflow
);
   localparam int                IDX_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_BURSTS - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST_BYTES);
   localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(NUM_BURSTS);

   typedef enum logic [2:0] {IDLE, WR_CMD, WR_ADV, RD_CMD, RD_ADV} state_t;

   state_t            state;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              wr_pend;
   logic              rd_pend;
   logic              last_wr;
   logic              wr_in_flight;
   logic              wr_drop;
   logic              wr_ok;
   logic              rd_ok;
   logic              pick_wr;
   logic              pick_rd;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [ADDR_W-1:0] rd_addr_nxt;

   // NOTE: the flags are decoded straight from the level register, so they
   // move in the same cycle as level with no extra flop of latency.
   assign ring_full  = (level == LVL_MAX);
   assign ring_empty = (level == '0);

   // Request filtering, arbitration between eligible bursts and burst addresses.
   always_comb begin
      wr_in_flight = (state == WR_CMD) || (state == WR_ADV);
      wr_drop      = bus.wr_req && (wr_pend || (ring_full && !wr_in_flight));
      wr_ok        = (state == IDLE) && calib_done && wr_pend && !ring_full;
      rd_ok        = (state == IDLE) && calib_done && rd_pend && !ring_empty;
      // Alternate when both are eligible; last_wr resets low so a write wins first.
      pick_wr      = wr_ok && (!rd_ok || !last_wr);
      pick_rd      = rd_ok && !pick_wr;
      // Modulo 2^ADDR_W by truncation to the address width.
      wr_addr_nxt  = BASE_ADDR + ADDR_W'(wr_idx) * STEP;
      rd_addr_nxt  = BASE_ADDR + ADDR_W'(rd_idx) * STEP;
   end

   // Pending-request capture and the sticky overflow flag; capture runs
   // regardless of calibration so early requests are not lost.
   always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
      if (addr_rstA_wr) begin
         wr_pend  <= 1'b0;
         rd_pend  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         // A request arriving while its flag is already set is absorbed
         // (write: counted as overflow), so clear-on-select can take priority.
         if (pick_wr)
            wr_pend <= 1'b0;
         else if (bus.wr_req && !wr_drop)
            wr_pend <= 1'b1;

         if (pick_rd)
            rd_pend <= 1'b0;
         else if (bus.rd_req)
            rd_pend <= 1'b1;

         if (wr_drop)
            overflow <= 1'b1;
      end
   end

   // Command sequencer: select in IDLE, strobe in *_CMD, commit pointers in *_ADV.
   always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
      if (addr_rstA_wr) begin
         state            <= IDLE;
         wr_idx           <= '0;
         rd_idx           <= '0;
         level            <= '0;
         last_wr          <= 1'b0;
         bus.cmd_en_wr    <= 1'b0;
         bus.cmd_en_rd    <= 1'b0;
         bus.wr_ack       <= 1'b0;
         bus.rd_ack       <= 1'b0;
         bus.wr_byte_addr <= BASE_ADDR;
         bus.rd_byte_addr <= BASE_ADDR;
      end else begin
         // NOTE: strobes default low every cycle and are raised only on the
         // transition into their state, which makes them exactly one cycle wide.
         bus.cmd_en_wr <= 1'b0;
         bus.cmd_en_rd <= 1'b0;
         bus.wr_ack    <= 1'b0;
         bus.rd_ack    <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_wr) begin
                  bus.wr_byte_addr <= wr_addr_nxt;
                  bus.cmd_en_wr    <= 1'b1;
                  last_wr          <= 1'b1;
                  state            <= WR_CMD;
               end else if (pick_rd) begin
                  bus.rd_byte_addr <= rd_addr_nxt;
                  bus.cmd_en_rd    <= 1'b1;
                  last_wr          <= 1'b0;
                  state            <= RD_CMD;
               end
            end
            WR_CMD: begin
               wr_idx     <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
               level      <= level + 1'b1;
               bus.wr_ack <= 1'b1;
               state      <= WR_ADV;
            end
            RD_CMD: begin
               rd_idx     <= (rd_idx == IDX_LAST) ? '0 : rd_idx + 1'b1;
               level      <= level - 1'b1;
               bus.rd_ack <= 1'b1;
               state      <= RD_ADV;
            end
            WR_ADV:  state <= IDLE;
            RD_ADV:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lpddr_burst_ring_sequencer.sv
// Directed bench for the burst ring sequencer, built with a 4-burst ring so
// fill, overflow and pointer wrap are reached quickly. A negedge monitor logs
// every command strobe with its address and cycle number.
module tb_lpddr_burst_ring_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        calib_done = 1'b0;
   logic [16:0] level;
   logic        ring_full;
   logic        ring_empty;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [29:0] wr_q[$];
   logic [29:0] rd_q[$];
   int          wr_t[$];
   int          rd_t[$];

   lpddr_burst_ring_sequencer_if #(.ADDR_W(30)) bus ();

   lpddr_burst_ring_sequencer #(.NUM_BURSTS(4)) u_dut (
      .clkA_addr    (clk),
      .addr_rstA_wr (rst),
      .calib_done   (calib_done),
      .bus          (bus),
      .level        (level),
      .ring_full    (ring_full),
      .ring_empty   (ring_empty),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // Command log, sampled half a cycle away from the active edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.cmd_en_wr === 1'b1) begin
         wr_q.push_back(bus.wr_byte_addr);
         wr_t.push_back(cyc);
      end
      if (bus.cmd_en_rd === 1'b1) begin
         rd_q.push_back(bus.rd_byte_addr);
         rd_t.push_back(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      wr_q.delete(); rd_q.delete(); wr_t.delete(); rd_t.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      step(2);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic do_write();
      bus.wr_req = 1'b1;
      step(1);
      bus.wr_req = 1'b0;
      step(5);
   endtask

   task automatic do_read();
      bus.rd_req = 1'b1;
      step(1);
      bus.rd_req = 1'b0;
      step(5);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      step(2);
      checks++;
      if ({bus.cmd_en_wr, bus.cmd_en_rd, bus.wr_ack, bus.rd_ack, overflow, ring_full, ring_empty} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000001",
                  {bus.cmd_en_wr, bus.cmd_en_rd, bus.wr_ack, bus.rd_ack, overflow, ring_full, ring_empty});
      end
      checks++;
      if (level !== 17'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++;
      if (bus.wr_byte_addr !== 30'h80 || bus.rd_byte_addr !== 30'h80) begin
         errors++;
         $display("FAIL reset_addr: got wr=%h rd=%h expected 80/80", bus.wr_byte_addr, bus.rd_byte_addr);
      end
      rst = 1'b0;
      clear_log();
   endtask

   task automatic test_single_write();
      apply_reset();
      calib_done = 1'b1;
      step(1);
      bus.wr_req = 1'b1;
      step(1);
      bus.wr_req = 1'b0;
      checks++;
      if (bus.cmd_en_wr !== 1'b0) begin errors++; $display("FAIL w1_early_cmd: got %b expected 0", bus.cmd_en_wr); end
      step(1);
      checks++;
      if (bus.cmd_en_wr !== 1'b1) begin errors++; $display("FAIL w1_cmd_latency: got %b expected 1", bus.cmd_en_wr); end
      checks++;
      if (bus.wr_byte_addr !== 30'h80) begin errors++; $display("FAIL w1_addr: got %h expected 80", bus.wr_byte_addr); end
      step(1);
      checks++;
      if ({bus.cmd_en_wr, bus.wr_ack} !== 2'b01) begin
         errors++;
         $display("FAIL w1_ack: got cmd/ack=%b expected 01", {bus.cmd_en_wr, bus.wr_ack});
      end
      checks++;
      if (bus.wr_byte_addr !== 30'h80) begin errors++; $display("FAIL w1_addr_hold: got %h expected 80", bus.wr_byte_addr); end
      step(1);
      checks++;
      if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL w1_ack_width: got %b expected 0", bus.wr_ack); end
      checks++;
      if (level !== 17'd1 || ring_empty !== 1'b0) begin
         errors++;
         $display("FAIL w1_level: got level=%0d empty=%b expected 1/0", level, ring_empty);
      end
   endtask

   task automatic test_arbitration();
      logic [29:0] exp_w[5];
      logic [29:0] exp_r[4];
      exp_w = '{30'h80, 30'h100, 30'h180, 30'h200, 30'h80};
      exp_r = '{30'h80, 30'h100, 30'h180, 30'h200};
      apply_reset();
      calib_done = 1'b1;
      // Four writes, three reads, one write, one read: leaves wr_idx=1,
      // rd_idx=0, level=1 with a read served last.
      repeat (4) do_write();
      repeat (3) do_read();
      do_write();
      do_read();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wr_q.size() <= i || wr_q[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL arb_setup_wr%0d: got %h expected %h", i, (wr_q.size() > i) ? wr_q[i] : 30'h0, exp_w[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_q.size() <= i || rd_q[i] !== exp_r[i]) begin
            errors++;
            $display("FAIL arb_setup_rd%0d: got %h expected %h", i, (rd_q.size() > i) ? rd_q[i] : 30'h0, exp_r[i]);
         end
      end
      clear_log();
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      step(1);
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      step(10);
      checks++;
      if (wr_q.size() != 1 || rd_q.size() != 1) begin
         errors++;
         $display("FAIL arb_counts: got wr=%0d rd=%0d expected 1/1", wr_q.size(), rd_q.size());
      end else begin
         checks++;
         if (wr_q[0] !== 30'h100 || rd_q[0] !== 30'h80) begin
            errors++;
            $display("FAIL arb_addr: got wr=%h rd=%h expected 100/80", wr_q[0], rd_q[0]);
         end
         checks++;
         if (rd_t[0] - wr_t[0] != 3) begin
            errors++;
            $display("FAIL arb_order: got rd-wr gap %0d expected 3", rd_t[0] - wr_t[0]);
         end
      end
      checks++;
      if (level !== 17'd1) begin errors++; $display("FAIL arb_level: got %0d expected 1", level); end
   endtask

   task automatic test_empty_read();
      apply_reset();
      calib_done = 1'b1;
      do_read();
      // Second request while the first is still pending: ignored, no overflow.
      do_read();
      checks++;
      if (rd_q.size() != 0) begin errors++; $display("FAIL empty_no_read: got %0d reads expected 0", rd_q.size()); end
      do_write();
      step(6);
      checks++;
      if (wr_q.size() != 1 || rd_q.size() != 1) begin
         errors++;
         $display("FAIL empty_counts: got wr=%0d rd=%0d expected 1/1", wr_q.size(), rd_q.size());
      end else begin
         checks++;
         if (rd_q[0] !== 30'h80 || rd_t[0] <= wr_t[0]) begin
            errors++;
            $display("FAIL empty_held_read: got addr=%h rd_t=%0d wr_t=%0d expected 80 after write", rd_q[0], rd_t[0], wr_t[0]);
         end
      end
      checks++;
      if (level !== 17'd0 || ring_empty !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL empty_final: got level=%0d empty=%b ovf=%b expected 0/1/0", level, ring_empty, overflow);
      end
   endtask

   task automatic test_wrap();
      logic [29:0] exp_w[4];
      exp_w = '{30'h80, 30'h100, 30'h180, 30'h200};
      apply_reset();
      calib_done = 1'b1;
      repeat (5) do_write();
      checks++;
      if (wr_q.size() != 4) begin errors++; $display("FAIL wrap_cmd_count: got %0d expected 4", wr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_q.size() <= i || wr_q[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL wrap_wr%0d: got %h expected %h", i, (wr_q.size() > i) ? wr_q[i] : 30'h0, exp_w[i]);
         end
      end
      checks++;
      if ({overflow, ring_full, ring_empty} !== 3'b110 || level !== 17'd4) begin
         errors++;
         $display("FAIL wrap_full: got ovf/full/empty=%b level=%0d expected 110/4", {overflow, ring_full, ring_empty}, level);
      end
      do_read();
      checks++;
      if (rd_q.size() != 1 || rd_q[0] !== 30'h80 || ring_full !== 1'b0 || level !== 17'd3) begin
         errors++;
         $display("FAIL wrap_read: got reads=%0d full=%b level=%0d expected 1 at 80, 0, 3", rd_q.size(), ring_full, level);
      end
      do_write();
      checks++;
      if (wr_q.size() != 5 || wr_q[4] !== 30'h80) begin
         errors++;
         $display("FAIL wrap_addr: got count=%0d last=%h expected 5 at 80", wr_q.size(), (wr_q.size() > 4) ? wr_q[4] : 30'h0);
      end
      checks++;
      if (overflow !== 1'b1 || level !== 17'd4) begin
         errors++;
         $display("FAIL wrap_sticky: got ovf=%b level=%0d expected 1/4", overflow, level);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      calib_done = 1'b1;
      // Second request lands just after the first was selected: accepted.
      bus.wr_req = 1'b1;
      step(1);
      bus.wr_req = 1'b0;
      step(1);
      bus.wr_req = 1'b1;
      step(1);
      bus.wr_req = 1'b0;
      step(6);
      checks++;
      if (wr_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 2", wr_q.size());
      end else begin
         checks++;
         if (wr_q[1] !== 30'h100 || wr_t[1] - wr_t[0] != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got addr=%h gap=%0d expected 100/3", wr_q[1], wr_t[1] - wr_t[0]);
         end
      end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf: got %b expected 0", overflow); end
      // Held for two cycles: the second cycle sees wr_pend still set and is dropped.
      bus.wr_req = 1'b1;
      step(2);
      bus.wr_req = 1'b0;
      step(6);
      checks++;
      if (wr_q.size() != 3 || overflow !== 1'b1 || level !== 17'd3) begin
         errors++;
         $display("FAIL b2b_drop: got count=%0d ovf=%b level=%0d expected 3/1/3", wr_q.size(), overflow, level);
      end
   endtask

   task automatic test_calib();
      apply_reset();
      calib_done = 1'b0;
      do_write();
      checks++;
      if (wr_q.size() != 0 || bus.cmd_en_wr !== 1'b0) begin
         errors++;
         $display("FAIL calib_hold: got %0d cmds expected 0", wr_q.size());
      end
      calib_done = 1'b1;
      step(1);
      checks++;
      if (bus.cmd_en_wr !== 1'b1 || bus.wr_byte_addr !== 30'h80) begin
         errors++;
         $display("FAIL calib_release: got cmd=%b addr=%h expected 1/80", bus.cmd_en_wr, bus.wr_byte_addr);
      end
      // Calibration lost mid-sequence: the burst still commits.
      calib_done = 1'b0;
      step(1);
      checks++;
      if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL calib_drop_ack: got %b expected 1", bus.wr_ack); end
      step(3);
      checks++;
      if (level !== 17'd1) begin errors++; $display("FAIL calib_drop_level: got %0d expected 1", level); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      calib_done = 1'b1;
      bus.wr_req = 1'b1;
      step(2);
      bus.wr_req = 1'b0;
      checks++;
      if (bus.cmd_en_wr !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre: got cmd=%b ovf=%b expected 1/1", bus.cmd_en_wr, overflow);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.cmd_en_wr !== 1'b0 || overflow !== 1'b0 || level !== 17'd0) begin
         errors++;
         $display("FAIL rmid_drop: got cmd=%b ovf=%b level=%0d expected 0/0/0", bus.cmd_en_wr, overflow, level);
      end
      checks++;
      if (bus.wr_byte_addr !== 30'h80 || bus.rd_byte_addr !== 30'h80) begin
         errors++;
         $display("FAIL rmid_addr: got wr=%h rd=%h expected 80/80", bus.wr_byte_addr, bus.rd_byte_addr);
      end
      step(1);
      rst = 1'b0;
      clear_log();
      do_write();
      checks++;
      if (wr_q.size() != 1 || wr_q[0] !== 30'h80 || level !== 17'd1) begin
         errors++;
         $display("FAIL rmid_next: got count=%0d addr=%h level=%0d expected 1 at 80, 1",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 30'h0, level);
      end
   endtask

   initial begin
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      #2;
      test_reset();
      test_single_write();
      test_arbitration();
      test_empty_read();
      test_wrap();
      test_back_to_back();
      test_calib();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
